// File: rtl/mips_instr_encoder_pkg.sv
// Shared MIPS encoding constants, op-select encoding and descriptor type.
// The instruction decoder imports the same constants.
package mips_instr_encoder_pkg;

  typedef enum logic [3:0] {
    OP_ADDIU = 4'd0,
    OP_JAL   = 4'd1,
    OP_ADDU  = 4'd2,
    OP_ADD   = 4'd3,
    OP_ADDI  = 4'd4,
    OP_SLT   = 4'd5,
    OP_BNE   = 4'd6,
    OP_BEQ   = 4'd7,
    OP_JR    = 4'd8,
    OP_SW    = 4'd9,
    OP_LW    = 4'd10
  } opSel_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bufState_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_LW    = 6'b100011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // op is kept as a raw vector so illegal selects 11-15 survive into the encoder.
  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
  } descriptor_t;

  function automatic logic [31:0] rType(input descriptor_t d, input logic [5:0] funct);
    return {OPC_RTYPE, d.rs, d.rt, d.rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] iType(input descriptor_t d, input logic [5:0] opcode);
    return {opcode, d.rs, d.rt, d.imm};
  endfunction

endpackage

// File: rtl/mips_encode_comb.sv
// Purely combinational mapping from an operation descriptor to a MIPS word.
// Unsupported op selects yield a zero word with illegal asserted.
module mips_encode_comb
  import mips_instr_encoder_pkg::*;
(
  input  descriptor_t desc,
  output logic [31:0] instr,
  output logic        illegal
);

  always_comb begin
    instr   = '0;
    illegal = 1'b0;
    case (desc.op)
      OP_ADDIU: instr = iType(desc, OPC_ADDIU);
      OP_JAL:   instr = {OPC_JAL, desc.target};
      OP_ADDU:  instr = rType(desc, FN_ADDU);
      OP_ADD:   instr = rType(desc, FN_ADD);
      OP_ADDI:  instr = iType(desc, OPC_ADDI);
      OP_SLT:   instr = rType(desc, FN_SLT);
      OP_BNE:   instr = iType(desc, OPC_BNE);
      OP_BEQ:   instr = iType(desc, OPC_BEQ);
      OP_JR:    instr = {OPC_RTYPE, desc.rs, 15'b0, FN_JR};
      OP_SW:    instr = iType(desc, OPC_SW);
      OP_LW:    instr = iType(desc, OPC_LW);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streaming MIPS instruction encoder: valid/ready in and out, one-word holding
// register, wrapping word-address counter, saturating word count, sticky error.
module mips_instr_encoder
  import mips_instr_encoder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   WC_MAX    = '1;

  bufState_e         state, nextState;
  descriptor_t       desc;
  logic [31:0]       encInstr;
  logic              encIllegal;
  logic [31:0]       instrReg;
  logic [ADDR_W-1:0] addrReg;
  logic [ADDR_W:0]   wordCountReg;
  logic              errReg;
  logic              inFire, outFire, legalFire;

  assign desc = '{op: in_op, rs: in_rs, rt: in_rt, rd: in_rd,
                  imm: in_imm, target: in_target};

  mips_encode_comb uEncode (
    .desc    (desc),
    .instr   (encInstr),
    .illegal (encIllegal)
  );

  assign out_valid = (state == FULL);
  assign in_ready  = !clear && (!out_valid || out_ready);

  // clear pre-empts the output side too, so no counter/count update on a cleared cycle.
  assign inFire    = in_valid && in_ready;
  assign outFire   = out_valid && out_ready && !clear;
  assign legalFire = inFire && !encIllegal;

  always_comb begin
    nextState = state;
    if (clear) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: if (legalFire) nextState = FULL;
        FULL:  if (outFire && !legalFire) nextState = EMPTY;
        default: nextState = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= EMPTY;
      instrReg     <= '0;
      addrReg      <= ADDR_BASE;
      wordCountReg <= '0;
      errReg       <= 1'b0;
    end else if (clear) begin
      state        <= EMPTY;
      instrReg     <= '0;
      addrReg      <= ADDR_BASE;
      wordCountReg <= '0;
      errReg       <= 1'b0;
    end else begin
      state <= nextState;
      if (legalFire) instrReg <= encInstr;
      if (outFire) begin
        addrReg <= (addrReg == ADDR_LAST) ? '0 : addrReg + ADDR_ONE;
        if (wordCountReg != WC_MAX) wordCountReg <= wordCountReg + WC_ONE;
      end
      if (inFire && encIllegal) errReg <= 1'b1;
    end
  end

  assign out_instr   = instrReg;
  assign out_addr    = addrReg;
  assign word_count  = wordCountReg;
  assign err_illegal = errReg;

endmodule
